ff_array_req_ctrl: RTL and testbench

- Request controller directly upstream of the 8x8 flip-flop array.
- Accepts a valid/ready command stream (WRITE, READ, CLEAR) and drives the array's wr/rd/addr/din so wr and rd are never asserted together.
- Captures the array's 1-cycle-latency read data into a response FIFO with valid/ready output.
- CLEAR is a multi-cycle sweep that writes zero to all 8 locations.

---
 rtl/ff_array_pkg.sv | 17 +
 rtl/ff_array_rsp_fifo.sv | 44 ++++
 rtl/ff_array_req_ctrl.sv | 91 +++++++++
 tb/tb_ff_array_req_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ff_array_pkg.sv
// ff_array_pkg: shared constants, command opcodes and FSM states for the 8x8 flip-flop array request path
package ff_array_pkg;
    localparam int DATA_W        = 8;
    localparam int ADDR_W        = 3;
    localparam int ARR_DEPTH     = 2 ** ADDR_W;
    localparam int RSP_DEPTH_DEF = 4;
    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_READ  = 2'd1,
        OP_CLEAR = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;
endpackage

// File: rtl/ff_array_rsp_fifo.sv
// ff_array_rsp_fifo: synchronous FIFO of {addr, data} read responses
// Ports: clk/resetn (sync, active-low), i_push/i_wdata write side, i_pop read side,
//        o_rdata head entry (holds the last popped entry while empty), o_count occupancy, o_empty.
module ff_array_rsp_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 11,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [W-1:0]  i_wdata,
    output logic [W-1:0]  o_rdata,
    output logic [CW-1:0] o_count,
    output logic          o_empty
);
    localparam int PW = $clog2(DEPTH);
    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wp, r_rp;
    logic [CW-1:0] r_count;
    logic [W-1:0]  r_hold;
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_hold  <= '0;
        end else begin
            if (i_push) r_wp <= r_wp + 1'b1;
            if (i_pop) begin
                r_rp   <= r_rp + 1'b1;
                r_hold <= r_mem[r_rp];
            end
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end
    always_ff @(posedge clk)
        if (i_push) r_mem[r_wp] <= i_wdata;
    assign o_empty = r_count == '0;
    assign o_count = r_count;
    // While empty, present the last consumed entry so the response bus holds still.
    assign o_rdata = o_empty ? r_hold : r_mem[r_rp];
endmodule

// File: rtl/ff_array_req_ctrl.sv
// ff_array_req_ctrl: command-to-array request controller with read-response FIFO and CLEAR sweep
// Ports: clk/resetn (sync, active-low); i_cmd_* / o_cmd_ready command stream (op 0=WRITE 1=READ 2=CLEAR 3=reserved);
//        o_arr_wr/o_arr_rd/o_arr_addr/o_arr_din drive the array, i_arr_dout (1-cycle latency) and i_arr_error come back;
//        o_rsp_valid/i_rsp_ready/o_rsp_data/o_rsp_addr response stream; o_busy during CLEAR; o_err_sticky until reset.
module ff_array_req_ctrl
    import ff_array_pkg::*;
#(
    parameter int RSP_DEPTH = RSP_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [1:0]        i_cmd_op,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [DATA_W-1:0] i_cmd_data,
    output logic              o_arr_wr,
    output logic              o_arr_rd,
    output logic [ADDR_W-1:0] o_arr_addr,
    output logic [DATA_W-1:0] o_arr_din,
    input  logic [DATA_W-1:0] i_arr_dout,
    input  logic              i_arr_error,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic [ADDR_W-1:0] o_rsp_addr,
    output logic              o_busy,
    output logic              o_err_sticky
);
    localparam int CW = $clog2(RSP_DEPTH) + 1;
    state_e                    r_state, w_next;
    logic [ADDR_W-1:0]         r_cnt, r_rd_addr;
    logic                      r_inflight, r_err;
    logic [CW-1:0]             w_count;
    logic                      w_empty;
    logic [CW:0]               w_used;
    op_e                       w_op;
    logic                      w_ready, w_acc, w_pop, w_is_rd, w_is_wr;
    logic [ADDR_W+DATA_W-1:0]  w_head;
    assign w_op    = op_e'(i_cmd_op);
    // Credit counts both queued responses and the read whose data lands next cycle.
    assign w_used  = {1'b0, w_count} + (CW+1)'(r_inflight);
    assign w_ready = (r_state == ST_RUN) && (w_used < (CW+1)'(RSP_DEPTH));
    assign w_acc   = i_cmd_valid && w_ready;
    assign w_is_wr = w_acc && (w_op == OP_WRITE);
    assign w_is_rd = w_acc && (w_op == OP_READ);
    assign w_pop   = o_rsp_valid && i_rsp_ready;
    always_ff @(posedge clk)
        r_state <= !resetn ? ST_RUN : w_next;
    always_comb begin
        w_next = (r_state == ST_RUN) ? ((w_acc && w_op == OP_CLEAR) ? ST_CLEAR : ST_RUN)
                                     : ((&r_cnt) ? ST_RUN : ST_CLEAR);
    end
    always_comb begin
        o_cmd_ready = w_ready;
        o_busy      = r_state == ST_CLEAR;
        o_arr_wr    = o_busy || w_is_wr;
        o_arr_rd    = w_is_rd;
        o_arr_addr  = o_busy ? r_cnt : (w_is_wr || w_is_rd) ? i_cmd_addr : '0;
        o_arr_din   = w_is_wr ? i_cmd_data : '0;
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt      <= '0;
            r_inflight <= 1'b0;
            r_rd_addr  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_cnt      <= (r_state == ST_CLEAR) ? r_cnt + 1'b1 : '0;
            r_inflight <= w_is_rd;
            if (w_is_rd) r_rd_addr <= i_cmd_addr;
            r_err      <= r_err || i_arr_error || (w_acc && w_op == OP_RSVD);
        end
    end
    ff_array_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .W     (ADDR_W + DATA_W)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (r_inflight),
        .i_pop   (w_pop),
        .i_wdata ({r_rd_addr, i_arr_dout}),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_empty (w_empty)
    );
    assign o_rsp_valid              = !w_empty;
    assign {o_rsp_addr, o_rsp_data} = w_head;
    assign o_err_sticky             = r_err;
endmodule

// File: tb/tb_ff_array_req_ctrl.sv
// tb_ff_array_req_ctrl: table-driven, directed and randomized checks of ff_array_req_ctrl against a transaction-level model
module tb_ff_array_req_ctrl;
    import ff_array_pkg::*;
    localparam int RD = 4;
    logic clk = 1'b0, resetn = 1'b0;
    logic cmd_valid = 1'b0, cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_data = '0;
    logic arr_wr, arr_rd, arr_error, force_err = 1'b0;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_din, arr_dout = '0;
    logic rsp_valid, rsp_ready = 1'b0, busy, err_sticky;
    logic [DATA_W-1:0] rsp_data;
    logic [ADDR_W-1:0] rsp_addr;

    always #5 clk = ~clk;

    ff_array_req_ctrl #(.RSP_DEPTH(RD)) dut (
        .clk(clk), .resetn(resetn),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_op(cmd_op),
        .i_cmd_addr(cmd_addr), .i_cmd_data(cmd_data),
        .o_arr_wr(arr_wr), .o_arr_rd(arr_rd), .o_arr_addr(arr_addr), .o_arr_din(arr_din),
        .i_arr_dout(arr_dout), .i_arr_error(arr_error),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data), .o_rsp_addr(rsp_addr),
        .o_busy(busy), .o_err_sticky(err_sticky)
    );

    // The flip-flop array the controller drives.
    logic [DATA_W-1:0] amem [ARR_DEPTH] = '{default: '0};
    always @(posedge clk) begin
        if (arr_wr) amem[arr_addr] <= arr_din;
        if (arr_rd) arr_dout <= amem[arr_addr];
    end
    assign arr_error = (arr_wr && arr_rd) || force_err;

    // Transaction-level model: memory contents, outstanding responses with visibility time, sweep length.
    typedef struct { logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; int rdy; } rsp_t;
    rsp_t q[$];
    logic [DATA_W-1:0] m_mem [ARR_DEPTH] = '{default: '0};
    int clr_left = 0, cyc = 0, n_cmp = 0, n_bad = 0, n_busy = 0;
    logic m_err = 1'b0;
    logic [ADDR_W-1:0] last_a = '0;
    logic [DATA_W-1:0] last_d = '0;
    logic [DATA_W-1:0] got[$];
    logic s_rdy, s_wr, s_rd, s_rv, s_busy, s_err;
    logic [DATA_W-1:0] s_rdata;
    logic [ADDR_W-1:0] s_raddr;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        bit ready, acc, vis;
        int ca;
        @(negedge clk);
        ready = clr_left == 0 && q.size() < RD;
        acc   = cmd_valid && ready;
        vis   = q.size() > 0 && q[0].rdy <= cyc;
        ca    = ARR_DEPTH - clr_left;
        {s_rdy, s_wr, s_rd, s_rv, s_busy, s_err} = {cmd_ready, arr_wr, arr_rd, rsp_valid, busy, err_sticky};
        s_rdata = rsp_data;
        s_raddr = rsp_addr;
        chk("cmd_ready", cmd_ready, ready);
        chk("arr_wr", arr_wr, clr_left > 0 || (acc && cmd_op == 2'd0));
        chk("arr_rd", arr_rd, acc && cmd_op == 2'd1);
        chk("wr_and_rd", arr_wr && arr_rd, 0);
        chk("arr_addr", arr_addr, clr_left > 0 ? ca : (acc && cmd_op < 2'd2) ? cmd_addr : 0);
        chk("arr_din", arr_din, (clr_left == 0 && acc && cmd_op == 2'd0) ? cmd_data : 0);
        chk("busy", busy, clr_left > 0);
        chk("rsp_valid", rsp_valid, vis);
        chk("rsp_data", rsp_data, vis ? q[0].d : last_d);
        chk("rsp_addr", rsp_addr, vis ? q[0].a : last_a);
        chk("err_sticky", err_sticky, m_err);
        if (busy) n_busy++;
        if (rsp_valid && rsp_ready) got.push_back(rsp_data);
        if (vis && rsp_ready) begin
            last_a = q[0].a;
            last_d = q[0].d;
            void'(q.pop_front());
        end
        if (clr_left > 0) begin
            m_mem[ca] = '0;
            clr_left--;
        end
        if (acc)
            case (cmd_op)
                2'd0: m_mem[cmd_addr] = cmd_data;
                2'd1: q.push_back('{cmd_addr, m_mem[cmd_addr], cyc + 2});
                2'd2: clr_left = ARR_DEPTH;
                default: m_err = 1'b1;
            endcase
        if (force_err) m_err = 1'b1;
        if (!resetn) begin
            q.delete();
            clr_left = 0;
            m_err = 1'b0;
            last_a = '0;
            last_d = '0;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    task automatic cmd(logic [1:0] op, int a, int d);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_addr = ADDR_W'(a);
        cmd_data = DATA_W'(d);
    endtask

    typedef struct {
        logic v; logic [1:0] op; logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; logic rr;
        logic e_rdy, e_wr, e_rd, e_rv; logic [DATA_W-1:0] e_d; logic [ADDR_W-1:0] e_a; logic e_err;
    } vec_t;
    vec_t tbl[7];

    initial begin
        int nacc;
        tbl[0] = '{1'b1, 2'd0, 3'd3, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0};
        tbl[1] = '{1'b1, 2'd1, 3'd3, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};
        tbl[2] = '{1'b0, 2'd0, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0};
        tbl[3] = '{1'b0, 2'd0, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 3'd3, 1'b0};
        tbl[4] = '{1'b0, 2'd0, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 3'd3, 1'b0};
        tbl[5] = '{1'b1, 2'd3, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 3'd3, 1'b0};
        tbl[6] = '{1'b0, 2'd0, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 3'd3, 1'b1};
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        tick();
        chk("rst_ready", s_rdy, 1);
        chk("rst_rsp_valid", s_rv, 0);
        chk("rst_busy", s_busy, 0);
        chk("rst_err", s_err, 0);
        chk("rst_rsp_data", s_rdata, 0);
        for (int i = 0; i < 7; i++) begin
            cmd_valid = tbl[i].v;
            cmd_op = tbl[i].op;
            cmd_addr = tbl[i].a;
            cmd_data = tbl[i].d;
            rsp_ready = tbl[i].rr;
            tick();
            chk("tbl_ready", s_rdy, tbl[i].e_rdy);
            chk("tbl_wr", s_wr, tbl[i].e_wr);
            chk("tbl_rd", s_rd, tbl[i].e_rd);
            chk("tbl_rsp_valid", s_rv, tbl[i].e_rv);
            chk("tbl_rsp_data", s_rdata, tbl[i].e_d);
            chk("tbl_rsp_addr", s_raddr, tbl[i].e_a);
            chk("tbl_err", s_err, tbl[i].e_err);
        end

        do_reset();
        for (int i = 0; i < 2000; i++) begin
            int r;
            r = $urandom_range(0, 31);
            cmd_valid = $urandom_range(0, 3) != 0;
            cmd_op = r < 14 ? 2'd0 : r < 29 ? 2'd1 : r < 31 ? 2'd2 : 2'd3;
            cmd_addr = ADDR_W'($urandom);
            cmd_data = DATA_W'($urandom);
            rsp_ready = $urandom_range(0, 3) != 0;
            tick();
        end

        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cmd(2'd0, i, (i + 1) * 17);
            tick();
        end
        got.delete();
        for (int i = 0; i < 8; i++) begin
            cmd(2'd1, i, 0);
            tick();
            chk("b2b_ready", s_rdy, 1);
        end
        cmd_valid = 1'b0;
        repeat (4) tick();
        chk("b2b_count", got.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < got.size()) chk("b2b_data", got[i], (i + 1) * 17);

        rsp_ready = 1'b0;
        nacc = 0;
        for (int i = 0; i < 8; i++) begin
            cmd(2'd1, i, 0);
            tick();
            if (s_rdy) nacc++;
        end
        chk("bp_accepts", nacc, 4);
        cmd_valid = 1'b0;
        tick();
        chk("bp_held_valid", s_rv, 1);
        got.delete();
        rsp_ready = 1'b1;
        repeat (8) tick();
        chk("bp_drain_count", got.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < got.size()) chk("bp_drain_data", got[i], (i + 1) * 17);

        cmd(2'd2, 5, 8'hFF);
        tick();
        cmd_valid = 1'b0;
        n_busy = 0;
        repeat (10) tick();
        chk("clr_busy_cycles", n_busy, 8);
        got.delete();
        for (int i = 0; i < 8; i++) begin
            cmd(2'd1, i, 0);
            tick();
        end
        cmd_valid = 1'b0;
        repeat (4) tick();
        chk("clr_read_count", got.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < got.size()) chk("clr_read_zero", got[i], 0);

        do_reset();
        cmd(2'd3, 5, 8'h5A);
        tick();
        chk("rsvd_no_wr", s_wr, 0);
        chk("rsvd_no_rd", s_rd, 0);
        cmd_valid = 1'b0;
        repeat (3) tick();
        chk("rsvd_err_set", s_err, 1);
        do_reset();
        tick();
        chk("fresh_err_clear", s_err, 0);
        force_err = 1'b1;
        tick();
        force_err = 1'b0;
        repeat (3) tick();
        chk("arr_error_sticky", s_err, 1);

        do_reset();
        cmd(2'd1, 1, 0);
        tick();
        cmd(2'd1, 2, 0);
        tick();
        cmd(2'd2, 0, 0);
        tick();
        cmd_valid = 1'b0;
        repeat (4) tick();
        chk("pre_rst_busy", s_busy, 1);
        chk("pre_rst_rsp_valid", s_rv, 1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        chk("mid_rst_rsp_valid", s_rv, 0);
        chk("mid_rst_busy", s_busy, 0);
        chk("mid_rst_ready", s_rdy, 1);
        chk("mid_rst_err", s_err, 0);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
